// File: rtl/inst_fetch.sv
// inst_fetch: program-counter sequencer with start/halt handshake and saturating retire/taken counters.
module inst_fetch #(
  parameter int PC_W   = 10,
  parameter int ICNT_W = 16,
  parameter int BCNT_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic              Cond,
  input  logic              JumpEn,
  input  logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Ack,
  output logic [ICNT_W-1:0] InstCount,
  output logic [BCNT_W-1:0] TakenCount
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [ICNT_W-1:0] ic_nxt;
  logic [BCNT_W-1:0] tc_nxt;
  logic run, hold, retire, taken;
  assign run    = state == RUN && !Start;
  assign hold   = Halt | Stall;
  assign retire = run & (Halt | !Stall);
  assign taken  = run & !hold & (JumpEn | (BranchEn & Cond));
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      InstCount  <= '0;
      TakenCount <= '0;
    end else begin
      state      <= state_nxt;
      ProgCtr    <= pc_nxt;
      InstCount  <= ic_nxt;
      TakenCount <= tc_nxt;
    end
  always_comb begin
    state_nxt = Start ? IDLE :
                state == IDLE ? RUN :
                (state == RUN && Halt) ? HALTED : state;
    // Halt outranks everything, so a halting jump leaves the PC on the halt instruction.
    pc_nxt = Start ? '0 :
             (!run || hold) ? ProgCtr :
             JumpEn ? Target :
             (BranchEn && Cond) ? ProgCtr + Target : ProgCtr + PC_W'(1);
    ic_nxt = Start ? '0 : (retire && !(&InstCount)) ? InstCount + ICNT_W'(1) : InstCount;
    tc_nxt = Start ? '0 : (taken && !(&TakenCount)) ? TakenCount + BCNT_W'(1) : TakenCount;
  end
  always_comb begin
    Running = state == RUN;
    Ack     = state == HALTED;
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenario tasks with hand-computed expectations for inst_fetch.
module tb_inst_fetch;
  logic Clk = 0, Reset, Start, Halt, Stall, BranchEn, Cond, JumpEn;
  logic [9:0] Target, ProgCtr;
  logic Running, Ack;
  logic [15:0] InstCount;
  logic [7:0] TakenCount;
  int n_vec = 0, n_err = 0;

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .BranchEn(BranchEn), .Cond(Cond), .JumpEn(JumpEn), .Target(Target),
    .ProgCtr(ProgCtr), .Running(Running), .Ack(Ack),
    .InstCount(InstCount), .TakenCount(TakenCount)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctl();
    Halt = 0; Stall = 0; BranchEn = 0; Cond = 0; JumpEn = 0; Target = '0;
  endtask

  task automatic test_reset();
    Reset = 1; Start = 1; clear_ctl();
    #2;
    n_vec++; if (ProgCtr !== 10'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", ProgCtr); end
    n_vec++; if (Running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", Running); end
    n_vec++; if (Ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", Ack); end
    n_vec++; if (InstCount !== 16'd0) begin n_err++; $display("FAIL reset_ic: got %0d want 0", InstCount); end
    n_vec++; if (TakenCount !== 8'd0) begin n_err++; $display("FAIL reset_tc: got %0d want 0", TakenCount); end
    step(); Reset = 0;
    step();
    n_vec++; if (Running !== 1'b0) begin n_err++; $display("FAIL start_held_running: got %b want 0", Running); end
  endtask

  task automatic test_sequential();
    Start = 0;
    step();
    n_vec++; if (Running !== 1'b1) begin n_err++; $display("FAIL seq_running: got %b want 1", Running); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (ProgCtr !== 10'(i)) begin n_err++; $display("FAIL seq_pc%0d: got %0d want %0d", i, ProgCtr, i); end
      step();
    end
    n_vec++; if (InstCount !== 16'd5) begin n_err++; $display("FAIL seq_ic: got %0d want 5", InstCount); end
    n_vec++; if (ProgCtr !== 10'd5) begin n_err++; $display("FAIL seq_pc_end: got %0d want 5", ProgCtr); end
  endtask

  task automatic test_branch();
    JumpEn = 1; Target = 10'd410; step(); clear_ctl();
    n_vec++; if (ProgCtr !== 10'd410) begin n_err++; $display("FAIL jmp410_pc: got %0d want 410", ProgCtr); end
    n_vec++; if (TakenCount !== 8'd1) begin n_err++; $display("FAIL jmp410_tc: got %0d want 1", TakenCount); end
    BranchEn = 1; Cond = 1; Target = 10'b1001101000; step(); clear_ctl();
    n_vec++; if (ProgCtr !== 10'd2) begin n_err++; $display("FAIL br_taken_pc: got %0d want 2", ProgCtr); end
    n_vec++; if (TakenCount !== 8'd2) begin n_err++; $display("FAIL br_taken_tc: got %0d want 2", TakenCount); end
    n_vec++; if (InstCount !== 16'd7) begin n_err++; $display("FAIL br_taken_ic: got %0d want 7", InstCount); end
    JumpEn = 1; Target = 10'd410; step(); clear_ctl();
    BranchEn = 1; Cond = 0; Target = 10'b1001101000; step(); clear_ctl();
    n_vec++; if (ProgCtr !== 10'd411) begin n_err++; $display("FAIL br_not_pc: got %0d want 411", ProgCtr); end
    n_vec++; if (TakenCount !== 8'd3) begin n_err++; $display("FAIL br_not_tc: got %0d want 3", TakenCount); end
    JumpEn = 1; BranchEn = 1; Cond = 1; Target = 10'd100; step(); clear_ctl();
    n_vec++; if (ProgCtr !== 10'd100) begin n_err++; $display("FAIL jmp_over_br_pc: got %0d want 100", ProgCtr); end
    n_vec++; if (TakenCount !== 8'd4) begin n_err++; $display("FAIL jmp_over_br_tc: got %0d want 4", TakenCount); end
    n_vec++; if (InstCount !== 16'd10) begin n_err++; $display("FAIL jmp_over_br_ic: got %0d want 10", InstCount); end
  endtask

  task automatic test_jump_wrap();
    JumpEn = 1; Target = 10'h3FF; step(); clear_ctl();
    n_vec++; if (ProgCtr !== 10'h3FF) begin n_err++; $display("FAIL wrap_jmp_pc: got %0h want 3ff", ProgCtr); end
    step();
    n_vec++; if (ProgCtr !== 10'h000) begin n_err++; $display("FAIL wrap_pc: got %0h want 0", ProgCtr); end
    n_vec++; if (InstCount !== 16'd12) begin n_err++; $display("FAIL wrap_ic: got %0d want 12", InstCount); end
  endtask

  task automatic test_stall_halt();
    JumpEn = 1; Target = 10'd7; step(); clear_ctl();
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (ProgCtr !== 10'd7) begin n_err++; $display("FAIL stall_pc%0d: got %0d want 7", i, ProgCtr); end
    end
    n_vec++; if (InstCount !== 16'd13) begin n_err++; $display("FAIL stall_ic: got %0d want 13", InstCount); end
    clear_ctl();
    Halt = 1; JumpEn = 1; Target = 10'd55; step(); clear_ctl();
    n_vec++; if (ProgCtr !== 10'd7) begin n_err++; $display("FAIL halt_pc: got %0d want 7", ProgCtr); end
    n_vec++; if (Ack !== 1'b1) begin n_err++; $display("FAIL halt_ack: got %b want 1", Ack); end
    n_vec++; if (Running !== 1'b0) begin n_err++; $display("FAIL halt_running: got %b want 0", Running); end
    n_vec++; if (InstCount !== 16'd14) begin n_err++; $display("FAIL halt_ic: got %0d want 14", InstCount); end
    n_vec++; if (TakenCount !== 8'd6) begin n_err++; $display("FAIL halt_tc: got %0d want 6", TakenCount); end
    JumpEn = 1; Target = 10'd55; step(); step(); clear_ctl();
    n_vec++; if (ProgCtr !== 10'd7) begin n_err++; $display("FAIL halted_pc: got %0d want 7", ProgCtr); end
    n_vec++; if (InstCount !== 16'd14) begin n_err++; $display("FAIL halted_ic: got %0d want 14", InstCount); end
    n_vec++; if (Ack !== 1'b1) begin n_err++; $display("FAIL halted_ack: got %b want 1", Ack); end
  endtask

  task automatic test_restart();
    Start = 1; step();
    n_vec++; if (Ack !== 1'b0) begin n_err++; $display("FAIL restart_ack: got %b want 0", Ack); end
    n_vec++; if (ProgCtr !== 10'd0) begin n_err++; $display("FAIL restart_pc: got %0d want 0", ProgCtr); end
    n_vec++; if (InstCount !== 16'd0 || TakenCount !== 8'd0) begin n_err++; $display("FAIL restart_cnt: got %0d/%0d want 0/0", InstCount, TakenCount); end
    Start = 0; step();
    n_vec++; if (Running !== 1'b1) begin n_err++; $display("FAIL restart_running: got %b want 1", Running); end
    for (int i = 0; i < 20; i++) step();
    n_vec++; if (ProgCtr !== 10'd20) begin n_err++; $display("FAIL run20_pc: got %0d want 20", ProgCtr); end
  endtask

  task automatic test_async_reset();
    #3 Reset = 1;
    #1;
    n_vec++; if (ProgCtr !== 10'd0 || InstCount !== 16'd0 || TakenCount !== 8'd0) begin n_err++; $display("FAIL areset_regs: got pc=%0d ic=%0d tc=%0d want 0", ProgCtr, InstCount, TakenCount); end
    n_vec++; if (Running !== 1'b0 || Ack !== 1'b0) begin n_err++; $display("FAIL areset_flags: got run=%b ack=%b want 0", Running, Ack); end
    Start = 1; step(); Reset = 0; step(); step();
    n_vec++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || InstCount !== 16'd0) begin n_err++; $display("FAIL areset_wait: got pc=%0d run=%b ic=%0d want 0", ProgCtr, Running, InstCount); end
    Start = 0; step();
    n_vec++; if (Running !== 1'b1 || ProgCtr !== 10'd0) begin n_err++; $display("FAIL areset_rerun: got run=%b pc=%0d want 1/0", Running, ProgCtr); end
    step();
    n_vec++; if (ProgCtr !== 10'd1 || InstCount !== 16'd1) begin n_err++; $display("FAIL areset_step: got pc=%0d ic=%0d want 1/1", ProgCtr, InstCount); end
  endtask

  task automatic test_saturate();
    JumpEn = 1; Target = 10'd5;
    for (int i = 0; i < 260; i++) step();
    clear_ctl();
    n_vec++; if (TakenCount !== 8'd255) begin n_err++; $display("FAIL tc_sat: got %0d want 255", TakenCount); end
    n_vec++; if (InstCount !== 16'd261) begin n_err++; $display("FAIL sat_ic: got %0d want 261", InstCount); end
    n_vec++; if (ProgCtr !== 10'd5) begin n_err++; $display("FAIL sat_pc: got %0d want 5", ProgCtr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_wrap();
    test_stall_halt();
    test_restart();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
